// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - 16x-oversampled 8N1 UART receiver with framing-error and break handling
module uart_rx_os16 #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rx_done_tick,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Start bit is judged half a bit in; data and stop bits a full bit after the previous sample.
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t                 state;
   logic                   rx_meta;
   logic                   rx_s;
   logic [TW-1:0]          tick_cnt;
   logic [BW-1:0]          bit_cnt;
   logic [DATA_BITS-1:0]   shift;

   // Two-flop resynchroniser; resets to the idle-high line level so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM: start validation, mid-bit data sampling, stop check, and break wait-out.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         data_out     <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         case (state)
            IDLE: begin
               // Edge detection runs every clk so the start-bit phase error is at most one tick.
               if (!rx_s) begin
                  tick_cnt <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_tick) begin
                  if (tick_cnt == TICK_MID) begin
                     if (!rx_s) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                     end else begin
                        // Line went back high before mid start bit: treat as noise.
                        state <= IDLE;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (baud_tick) begin
                  if (tick_cnt == TICK_LAST) begin
                     shift    <= {rx_s, shift[DATA_BITS-1:1]};
                     tick_cnt <= '0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= STOP;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (baud_tick) begin
                  if (tick_cnt == TICK_LAST) begin
                     if (rx_s) begin
                        data_out     <= shift;
                        rx_done_tick <= 1'b1;
                        state        <= IDLE;
                     end else begin
                        // Bad stop bit: keep the previous good byte and wait for the line to recover.
                        frame_err <= 1'b1;
                        state     <= BREAK;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            BREAK: begin
               // A held-low line must not be re-read as a stream of zero frames.
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- 8N1 UART receiver, the counterpart to the team's 16x-oversampled UART transmitter.
- Shares the same baud_tick generator: baud_tick pulses at 16x the bit rate.
- Resynchronises the asynchronous rx line, detects and validates the start bit, samples each data bit at mid-bit, and checks the stop bit.
- Presents the received byte with a one-cycle done pulse. Flags framing errors and waits out line breaks.

Parameters:
- OVERSAMPLE, 16, baud_ticks per bit; must be a power of 2, >= 8.
- DATA_BITS, 8, data bits per frame, LSB first.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- baud_tick  input  1  one-clk-wide pulse at OVERSAMPLE x bit rate
- rx  input  1  asynchronous serial line, idle high
- data_out  output  DATA_BITS  last correctly received byte, held until the next good frame
- rx_done_tick  output  1  one-clk pulse when data_out is updated
- frame_err  output  1  one-clk pulse when the stop bit is sampled low
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset is the only way every register is initialised. Reset values:
  - Sync flops = 1; state = IDLE; tick_cnt = 0; bit_cnt = 0; shift = 0.
  - data_out = 0; rx_done_tick = 0; frame_err = 0; busy = 0.
  - Reset mid-frame aborts the frame immediately: no done or error pulse, data_out returns to 0.
- Synchroniser: rx passes through 2 flops to give rx_s, so there are 2 clk of latency. All decisions use rx_s only.
- tick_cnt width is log2(OVERSAMPLE). It advances only on clk cycles with baud_tick = 1. There is no activity between ticks.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - If rx_s = 0 (checked every clk, not only on ticks): tick_cnt <= 0, go to START.
- START:
  - On a tick with tick_cnt = OVERSAMPLE/2 - 1 (7), this is the mid start bit.
  - If rx_s = 0: tick_cnt <= 0, bit_cnt <= 0, go to DATA.
  - If rx_s = 1 (glitch): go to IDLE, with no pulse.
  - Otherwise on a tick: tick_cnt++.
- DATA:
  - On a tick with tick_cnt = OVERSAMPLE-1: shift <= {rx_s, shift[DATA_BITS-1:1]} (LSB first), tick_cnt <= 0.
  - If bit_cnt = DATA_BITS-1, go to STOP; else bit_cnt++.
  - Otherwise on a tick: tick_cnt++.
- STOP:
  - On a tick with tick_cnt = OVERSAMPLE-1 (mid stop bit):
    - If rx_s = 1: data_out <= shift, rx_done_tick <= 1, go to IDLE.
    - If rx_s = 0: frame_err <= 1, data_out unchanged, go to BREAK.
  - Otherwise on a tick: tick_cnt++.
- BREAK:
  - Stay until rx_s = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Pulses are registered: they are high exactly 1 clk, in the cycle after the deciding tick. rx_done_tick and frame_err are never high together.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge half a bit later is caught. No minimum idle time is required beyond that.
- busy is combinational from state.

Test Plan:
- Baud_tick every 4 clk; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one rx_done_tick, data_out = 0xA5, frame_err never high, busy low after the pulse.
- rx low for 3 baud_ticks then high (glitch) -> FSM returns to IDLE by the 8th tick, no pulses, data_out unchanged, busy low.
- Good frame 0x5A, then frame 0x3C with stop bit 0 held low for 40 ticks, then high -> frame_err single pulse; data_out stays 0x5A; busy high through the break, low after rx returns high; next good frame 0x81 is received correctly.
- Back-to-back 0x00 then 0xFF with zero idle between stop and next start -> two rx_done_ticks, values 0x00 then 0xFF.
- rst asserted for 1 clk during data bit 4 of a frame -> outputs at reset values next cycle, no pulse. A subsequent clean frame 0xC3 is received correctly.
- baud_tick held low for 100 clk mid-frame -> state and counters frozen; the frame completes correctly once ticks resume.
